// File: rtl/input_handshake_controller_if.sv
// Handshake bundle between the control unit / operator panel and the IN-instruction controller.
// With INPUT_TIMEOUT_EN defined the bundle also carries the sticky timed_out flag.
interface input_handshake_controller_if;
  logic        inputEnable;
  logic [16:0] switches;
  logic        confirm_n;
  logic [31:0] data_out;
  logic        data_valid;
  logic        stall;
  logic        waiting;
`ifdef INPUT_TIMEOUT_EN
  logic        timed_out;

  modport master (output inputEnable, switches, confirm_n,
                  input  data_out, data_valid, stall, waiting, timed_out);
  modport slave  (input  inputEnable, switches, confirm_n,
                  output data_out, data_valid, stall, waiting, timed_out);
`else
  modport master (output inputEnable, switches, confirm_n,
                  input  data_out, data_valid, stall, waiting);
  modport slave  (input  inputEnable, switches, confirm_n,
                  output data_out, data_valid, stall, waiting);
`endif
endinterface

// File: rtl/input_handshake_controller.sv
// IN-instruction controller: stalls the PC, waits for a debounced confirm press and
// delivers the sign-extended switch value. Optional request timeout under INPUT_TIMEOUT_EN.
module input_handshake_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
`ifdef INPUT_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd500000000
`endif
) (
  input logic                         clk,
  input logic                         reset,
  input_handshake_controller_if.slave io
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_PRESS, CAPTURE, DONE} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef INPUT_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;
`endif

  logic             cn_s1, cn_s2;
  logic             deb;
  logic [CNT_W-1:0] db_cnt;
  logic             key_down_q;
  logic [16:0]      sw_s1, sw_s2;

  state_t           state;
  logic             busy_q;
  logic             waiting_q;
  logic             valid_q;
  logic [31:0]      data_q;
`ifdef INPUT_TIMEOUT_EN
  logic [31:0]      tmr;
  logic             to_q;
`endif

  logic key_down;
  logic press_edge;

  assign key_down   = ~deb;
  assign press_edge = key_down & ~key_down_q;

  // Synchronizers and debouncer. Key flops reset to 1 so a released key looks released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cn_s1      <= 1'b1;
      cn_s2      <= 1'b1;
      deb        <= 1'b1;
      db_cnt     <= '0;
      key_down_q <= 1'b0;
      sw_s1      <= '0;
      sw_s2      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes cn_s1 -> cn_s2 a real two-stage pipeline.
      cn_s1      <= io.confirm_n;
      cn_s2      <= cn_s1;
      sw_s1      <= io.switches;
      sw_s2      <= sw_s1;
      key_down_q <= ~deb;
      if (cn_s2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb    <= cn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      waiting_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
`ifdef INPUT_TIMEOUT_EN
      tmr       <= '0;
      to_q      <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io.inputEnable) begin
            state     <= ARM;
            busy_q    <= 1'b1;
            waiting_q <= 1'b1;
`ifdef INPUT_TIMEOUT_EN
            tmr       <= '0;
            to_q      <= 1'b0;
`endif
          end
        end
        ARM, WAIT_PRESS: begin
`ifdef INPUT_TIMEOUT_EN
          tmr <= tmr + 32'd1;
`endif
          if (!io.inputEnable) begin
            // Request withdrawn: abandon quietly, data_out keeps its old value.
            state     <= IDLE;
            busy_q    <= 1'b0;
            waiting_q <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
          end else if (tmr == TO_LAST) begin
            state     <= DONE;
            data_q    <= '0;
            to_q      <= 1'b1;
            busy_q    <= 1'b0;
            waiting_q <= 1'b0;
            valid_q   <= 1'b1;
`endif
          end else if (state == ARM) begin
            // A key still held from the previous IN must be released first.
            if (!key_down) state <= WAIT_PRESS;
          end else if (press_edge) begin
            state     <= CAPTURE;
            waiting_q <= 1'b0;
          end
        end
        CAPTURE: begin
          data_q  <= {{15{sw_s2[16]}}, sw_s2};
          state   <= DONE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall must hold the PC in the very cycle the request appears, but never during reset.
  assign io.stall      = busy_q | ((state == IDLE) & io.inputEnable & reset);
  assign io.data_out   = data_q;
  assign io.data_valid = valid_q;
  assign io.waiting    = waiting_q;
`ifdef INPUT_TIMEOUT_EN
  assign io.timed_out  = to_q;
`endif

endmodule

// File: tb/tb_input_handshake_controller.sv
// Self-checking bench for input_handshake_controller: directed scenarios plus random
// operator behaviour, compared every cycle against a flag-based behavioural model.
`timescale 1ns/1ps
module tb_input_handshake_controller;

  localparam int DB = 4;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ie = 1'b0;
  logic [16:0] sw = '0;
  logic        cn = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  input_handshake_controller_if bus ();
  assign bus.inputEnable = ie;
  assign bus.switches    = sw;
  assign bus.confirm_n   = cn;

  input_handshake_controller #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(16)
`ifdef INPUT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32'd100)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  // Behavioural reference: key as seen two clocks late, debounced by run length,
  // and the transaction described as a handful of progress flags.
  bit          m_s1, m_s2, m_deb, m_kdp;
  int          m_run;
  bit          m_busy, m_rel, m_cap, m_valid, m_to;
  int          m_tmr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_deb = 1; m_kdp = 0; m_run = 0;
    m_busy = 0; m_rel = 0; m_cap = 0; m_valid = 0; m_to = 0; m_tmr = 0;
    m_data = '0;
  endtask

  task automatic model_edge();
    bit kd;
    bit timeout_hit;
    kd = !m_deb;
    timeout_hit = 1'b0;
`ifdef INPUT_TIMEOUT_EN
    timeout_hit = (m_tmr == TO - 1);
`endif
    if (m_valid) begin
      m_valid = 0;
    end else if (m_cap) begin
      m_cap = 0;
      m_data = {{15{sw[16]}}, sw};
      m_valid = 1;
    end else if (m_busy) begin
      if (!ie) begin
        m_busy = 0;
      end else if (timeout_hit) begin
        m_busy = 0; m_data = '0; m_to = 1; m_valid = 1;
      end else begin
        m_tmr++;
        if (!m_rel) begin
          if (!kd) m_rel = 1;
        end else if (kd && !m_kdp) begin
          m_busy = 0; m_cap = 1;
        end
      end
    end else if (ie) begin
      m_busy = 1; m_rel = 0; m_tmr = 0; m_to = 0;
    end
    m_kdp = kd;
    if (m_s2 != m_deb) begin
      m_run++;
      if (m_run == DB) begin
        m_deb = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = cn;
  endtask

  task automatic compare_all();
    logic exp_stall;
    exp_stall = (m_busy || m_cap) ? 1'b1 : (m_valid ? 1'b0 : (ie & reset));
    check("data_valid", 32'(bus.data_valid), 32'(m_valid));
    check("stall", 32'(bus.stall), 32'(exp_stall));
    check("waiting", 32'(bus.waiting), 32'(m_busy));
    check("data_out", bus.data_out, m_data);
`ifdef INPUT_TIMEOUT_EN
    check("timed_out", 32'(bus.timed_out), 32'(m_to));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    compare_all();
    if (bus.data_valid) pulses++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.data_valid && n < budget);
    check("valid_within_budget", 32'(bus.data_valid), 32'd1);
  endtask

  task automatic do_in(input logic [16:0] v, input logic [31:0] exp, input string tag);
    sw = v; cn = 1; ie = 1;
    steps(3);
    cn = 0;
    wait_valid(40);
    check(tag, bus.data_out, exp);
    check({tag, "_stall_in_done"}, 32'(bus.stall), 32'd0);
    ie = 0;
    step();
    cn = 1;
    steps(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1;
    steps(3);

    // 1: clean press; stall must assert combinationally with the request.
    sw = 17'h0002A; cn = 1; ie = 1;
    #1;
    check("req_stall_same_cycle", 32'(bus.stall), 32'd1);
    ie = 0;
    step();
    do_in(17'h0002A, 32'h0000002A, "t1_data");

    // 2: sign extension.
    do_in(17'h1FFFF, 32'hFFFFFFFF, "t2_all_ones");
    do_in(17'h10000, 32'hFFFF0000, "t2_msb_only");

    // 3: bouncing key must not capture; stable low gives exactly one capture.
    sw = 17'h00155; cn = 1; ie = 1;
    steps(3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cn = 0; steps(2);
      cn = 1; steps(2);
    end
    check("t3_no_capture_in_bounce", 32'(pulses), 32'd0);
    cn = 0;
    steps(15);
    check("t3_single_capture", 32'(pulses), 32'd1);
    check("t3_data", bus.data_out, 32'h00000155);
    ie = 0; cn = 1;
    steps(8);

    // 4: key held before the request, then back-to-back requests.
    cn = 0;
    steps(10);
    pulses = 0;
    sw = 17'h0ABCD; ie = 1;
    steps(12);
    check("t4_held_key_ignored", 32'(pulses), 32'd0);
    cn = 1; steps(8);
    cn = 0; steps(12);
    check("t4_first_capture", 32'(pulses), 32'd1);
    cn = 1; steps(8);
    cn = 0; steps(12);
    check("t4_second_capture", 32'(pulses), 32'd2);
    ie = 0; cn = 1;
    steps(8);

    // 5: abort during WAIT_PRESS, then reset during CAPTURE.
    pulses = 0;
    sw = 17'h00777; ie = 1;
    steps(4);
    ie = 0;
    step();
    check("t5_abort_stall", 32'(bus.stall), 32'd0);
    check("t5_abort_data_hold", bus.data_out, 32'h0000ABCD);
    steps(3);
    check("t5_abort_no_valid", 32'(pulses), 32'd0);
    ie = 1;
    steps(3);
    cn = 0;
    begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (!m_cap && n < 30);
    end
    check("t5_in_capture", {30'd0, bus.stall, bus.waiting}, 32'd2);
    reset = 0;
    #1;
    model_reset();
    compare_all();
    check("t5_reset_outputs", {bus.data_out[29:0], bus.data_valid, bus.stall}, 32'd0);
    steps(2);
    reset = 1; ie = 0; cn = 1;
    steps(8);

`ifdef INPUT_TIMEOUT_EN
    // 6: unanswered request auto-completes with zero data.
    begin
      int n;
      ie = 1; cn = 1; n = 0;
      do begin
        step();
        n++;
      end while (!bus.data_valid && n < 300);
      check("t6_timeout_latency", 32'(n), 32'd101);
      check("t6_data_zero", bus.data_out, 32'd0);
      check("t6_timed_out", 32'(bus.timed_out), 32'd1);
      step();
      step();
      check("t6_timed_out_cleared", 32'(bus.timed_out), 32'd0);
      ie = 0;
      steps(4);
    end
`endif

    // Random operator behaviour.
    for (int seg = 0; seg < 400; seg++) begin
      if (!m_busy && !m_cap && !m_valid && ($urandom % 4 == 0)) sw = 17'($urandom);
      ie = ($urandom % 8) != 0;
      cn = 1'($urandom % 2);
      steps($urandom_range(1, 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
